// File: rtl/risc_v_enc_pkg.sv
// risc_v_enc_pkg: shared format/state enums and the NOP word for the RISC-V encoder.
package risc_v_enc_pkg;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/risc_v_enc_fifo.sv
// risc_v_enc_fifo: synchronous FIFO buffering encoded words with their addresses.
module risc_v_enc_fifo #(
  parameter int W = 40,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = wp == {~rp[AW], rp[AW-1:0]};
  assign dout = mem[rp[AW-1:0]];
  // Storage is cleared on reset so the head reads zero while idle.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push && !full) begin
        mem[wp[AW-1:0]] <= din;
        wp <= wp + 1'b1;
      end
      if (pop && !empty) rp <= rp + 1'b1;
    end
endmodule

// File: rtl/risc_v_encoder.sv
// risc_v_encoder: packs RISC-V instruction fields into words with byte addresses.
// Define RISCV_ENC_ILLEGAL_CHK_EN to replace illegal inputs with NOP and flag err.
module risc_v_encoder
  import risc_v_enc_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        func3,
  input  logic [6:0]        func7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              done,
  output logic              err
);
  state_t state;
  logic [ADDR_W-1:0] addr;
  logic full, empty, push;
  logic [31:0] word, enc;
  logic [32+ADDR_W-1:0] q;
  assign in_ready = state == RUN && !full;
  assign push = in_valid && in_ready;
  assign out_valid = !empty;
  assign {out_instr, out_addr} = q;
  always_comb
    word = fmt == FMT_I ? {imm[11:0], rs1, func3, rd, opcode} :
           fmt == FMT_S ? {imm[11:5], rs2, rs1, func3, imm[4:0], opcode} :
           fmt == FMT_B ? {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode} :
           fmt == FMT_U ? {imm[31:12], rd, opcode} :
           fmt == FMT_J ? {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode} :
                          {func7, rs2, rs1, func3, rd, opcode};
`ifdef RISCV_ENC_ILLEGAL_CHK_EN
  logic legal, err_q;
  assign legal = fmt <= 3'd5 && opcode[1:0] == 2'b11 &&
                 !(imm[0] && (fmt == FMT_B || fmt == FMT_J));
  assign enc = legal ? word : NOP;
  assign err = err_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) err_q <= 1'b0;
    else if (push && !legal) err_q <= 1'b1;
`else
  assign enc = word;
  assign err = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          addr <= base_addr;
        end
        RUN: if (push) begin
          addr <= addr + ADDR_W'(4);
          if (in_last) state <= DRAIN;
        end
        DRAIN: if (empty) begin
          state <= IDLE;
          done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  risc_v_enc_fifo #(.W(32 + ADDR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(out_ready), .din({enc, addr}),
    .dout(q), .full(full), .empty(empty)
  );
endmodule

// File: tb/tb_risc_v_encoder.sv
// tb_risc_v_encoder: directed checks of encoding, buffering, addressing, reset and done.
module tb_risc_v_encoder;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, in_last = 0, out_ready = 0;
  logic [7:0] base_addr = 0;
  logic [2:0] fmt = 0, func3 = 0;
  logic [6:0] opcode = 0, func7 = 0;
  logic [4:0] rd = 0, rs1 = 0, rs2 = 0;
  logic [31:0] imm = 0;
  logic in_ready, out_valid, done, err;
  logic [31:0] out_instr;
  logic [7:0] out_addr;
  int errors = 0, checks = 0;
  int acc, got;

  risc_v_encoder dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .fmt(fmt), .opcode(opcode), .rd(rd),
    .rs1(rs1), .rs2(rs2), .func3(func3), .func7(func7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] b);
    start = 1;
    base_addr = b;
    @(negedge clk);
    start = 0;
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] im, input logic last,
                      input logic [31:0] ew, input logic [7:0] ea, input string tag);
    int n = 0;
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; func3 = f3; func7 = f7;
    imm = im; in_last = last; in_valid = 1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 0;
    in_last = 0;
    chk({tag, " out_valid"}, out_valid, 1);
    chk({tag, " instr"}, out_instr, ew);
    chk({tag, " addr"}, out_addr, ea);
  endtask

  task automatic set_i(input int k);
    fmt = 1; opcode = 7'h13; rd = 1; rs1 = 0; func3 = 0; imm = k + 1; in_last = k == 2;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) n++;
    end
    chk(tag, n, 1);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 0);
    chk("rst out_instr", out_instr, 0);
    chk("rst out_addr", out_addr, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    rst = 0;
    out_ready = 1;
    @(negedge clk);
    chk("idle in_ready", in_ready, 0);
    do_start(8'h10);
    send(0, 7'h33, 3, 1, 2, 0, 0, 0, 0, 32'h002081B3, 8'h10, "R add");
    send(1, 7'h13, 1, 0, 0, 0, 0, 5, 0, 32'h00500093, 8'h14, "I addi");
    send(2, 7'h23, 0, 1, 2, 2, 0, 8, 0, 32'h0020A423, 8'h18, "S sw");
    send(4, 7'h37, 5, 0, 0, 0, 0, 32'h12345000, 0, 32'h123452B7, 8'h1C, "U lui");
    send(3, 7'h63, 0, 0, 0, 0, 0, 32'hFFFFFFFC, 0, 32'hFE000EE3, 8'h20, "B beq");
    send(5, 7'h6F, 1, 0, 0, 0, 0, 8, 1, 32'h008000EF, 8'h24, "J jal");
    wait_done("done pulse seq1");
    chk("idle after done", in_ready, 0);
    // Backpressure: two-entry buffer fills, third beat waits.
    out_ready = 0;
    do_start(8'h10);
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      set_i(acc);
      in_valid = 1;
      if (acc > 0) begin
        chk("hold instr", out_instr, 32'h00100093);
        chk("hold addr", out_addr, 8'h10);
      end
      if (in_ready) acc++;
      @(negedge clk);
    end
    chk("accepted while stalled", acc, 2);
    chk("stalled in_ready", in_ready, 0);
    out_ready = 1;
    got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      set_i(acc);
      in_valid = acc < 3;
      if (out_valid) begin
        chk("order instr", out_instr, 32'h00000093 | ((got + 1) << 20));
        chk("order addr", out_addr, 8'(8'h10 + 4 * got));
        got++;
      end
      if (in_valid && in_ready) acc++;
      @(negedge clk);
    end
    in_valid = 0;
    in_last = 0;
    chk("drained count", got, 3);
    wait_done("done pulse seq2");
    // Address wrap.
    do_start(8'hFC);
    send(0, 7'h33, 3, 1, 2, 0, 0, 0, 0, 32'h002081B3, 8'hFC, "wrap0");
    send(1, 7'h13, 1, 0, 0, 0, 0, 5, 1, 32'h00500093, 8'h00, "wrap1");
    wait_done("done pulse wrap");
    // Reset mid-RUN with a word buffered.
    out_ready = 0;
    do_start(8'h40);
    send(1, 7'h13, 1, 0, 0, 0, 0, 5, 0, 32'h00500093, 8'h40, "pre-rst");
    #2 rst = 1;
    #1;
    chk("mid rst out_valid", out_valid, 0);
    chk("mid rst in_ready", in_ready, 0);
    chk("mid rst out_instr", out_instr, 0);
    chk("mid rst out_addr", out_addr, 0);
    @(negedge clk);
    rst = 0;
    in_valid = 1;
    @(negedge clk);
    chk("idle ignores beat", out_valid, 0);
    in_valid = 0;
    out_ready = 1;
    do_start(8'h00);
`ifdef RISCV_ENC_ILLEGAL_CHK_EN
    send(6, 7'h33, 3, 1, 2, 0, 0, 0, 0, 32'h00000013, 8'h00, "fmt6 nop");
    chk("err set", err, 1);
`else
    send(6, 7'h33, 3, 1, 2, 0, 0, 0, 0, 32'h002081B3, 8'h00, "fmt6 as R");
    chk("err tied", err, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/risc_v_encoder.md
RISC_V_ENCODER -- requirements
Module: risc_v_encoder

Interface
REQ-001 Parameter ADDR_W, default 8, byte-address width of out_addr.
REQ-002 Parameter FIFO_DEPTH, default 2, output buffer entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  begin a program; loads base_addr.
REQ-006 base_addr  input  ADDR_W  first byte address of the program.
REQ-007 in_valid / in_ready  input / output  1 each  field-side handshake.
REQ-008 in_last  input  1  marks the final instruction of the program.
REQ-009 fmt  input  3  format: R=0, I=1, S=2, B=3, U=4, J=5.
REQ-010 opcode / rd / rs1 / rs2 / func3 / func7  input  7/5/5/5/3/7  instruction fields.
REQ-011 imm  input  32  immediate, unscrambled, sign-extended.
REQ-012 out_valid / out_ready  output / input  1 each  word-side handshake.
REQ-013 out_instr  output  32  encoded instruction word.
REQ-014 out_addr  output  ADDR_W  byte address paired with out_instr.
REQ-015 done  output  1  one-cycle pulse when the program has fully drained.
REQ-016 err  output  1  sticky illegal-input flag.

Function
REQ-017 FSM states IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN on accepted beat with in_last=1; DRAIN->IDLE when the FIFO is empty, asserting done in that cycle.
REQ-018 in_ready = (state==RUN) && FIFO not full; it depends on no combinational path from out_ready.
REQ-019 Input beat accepted when in_valid && in_ready; fields encoded combinationally and written to FIFO in the same edge.
REQ-020 Encoding: R {func7,rs2,rs1,func3,rd,opcode}; I {imm[11:0],rs1,func3,rd,opcode}; S {imm[11:5],rs2,rs1,func3,imm[4:0],opcode}.
REQ-021 Encoding: B {imm[12],imm[10:5],rs2,rs1,func3,imm[4:1],imm[11],opcode}; U {imm[31:12],rd,opcode}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}.
REQ-022 Latency: accepted beat appears on out_instr with out_valid=1 the next cycle when the FIFO was empty.
REQ-023 Address counter loads base_addr on start; each accepted beat stores the current address with its word, then adds 4 modulo 2^ADDR_W (wrap silent).
REQ-024 Output transfer when out_valid && out_ready; simultaneous push and pop on a full FIFO is not possible (in_ready=0); simultaneous push and pop otherwise keeps occupancy unchanged.
REQ-025 start while in RUN or DRAIN is ignored; in_valid in IDLE or DRAIN is not accepted.
REQ-026 out_instr/out_addr hold stable while out_valid=1 and out_ready=0.

Reset
REQ-027 rst asserted: state IDLE, FIFO emptied, address 0, out_valid=0, in_ready=0, done=0, err=0, out_instr=0, out_addr=0, effective immediately, mid-operation included; in-flight words discarded.

Configuration
REQ-028 Macro RISCV_ENC_ILLEGAL_CHK_EN defined: fmt>5, opcode[1:0]!=2'b11, or imm[0]=1 for B/J make the word 32'h0000_0013 (NOP) and set err until rst.
REQ-029 Macro undefined: no checking, fmt>5 encodes as R, imm[0] ignored, err tied 0.

Structure
REQ-030 Package risc_v_enc_pkg holds the fmt enum, state enum and NOP constant.
REQ-031 Sub-module risc_v_enc_fifo (synchronous FIFO, 32+ADDR_W wide, FIFO_DEPTH deep) holds the output buffer.

Verification
REQ-032 start, base_addr=8'h10; R add x3,x1,x2 (op 0x33) -> out_instr 0x002081B3, out_addr 0x10 one cycle later.
REQ-033 I addi x1,x0,5 -> 0x00500093; S sw x2,8(x1) -> 0x0020A423; U lui x5,0x12345 -> 0x123452B7.
REQ-034 B beq x0,x0,imm=-4 -> 0xFE000EE3; J jal x1,imm=8 with in_last -> 0x008000EF, then done pulses once after drain.
REQ-035 out_ready=0 for 5 cycles with 3 beats offered -> in_ready drops after 2 accepted, output held stable, no loss; release -> order and addresses 0x10,0x14,0x18.
REQ-036 base_addr=8'hFC, two beats -> addresses 0xFC then 0x00; rst mid-RUN -> out_valid=0 same cycle, IDLE; with macro, fmt=6 -> 0x00000013 and err=1.
